// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and defaults for the shift/subtract divider
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int DIV_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/shift_sub_divider_shift_left_reg.sv
// rtl/shift_sub_divider_shift_left_reg.sv - {R,Q} register pair shifting left one bit per step
module shift_left_reg #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Load_En,
    input  logic             Clr_En,
    input  logic             Shift_En,
    input  logic [WIDTH-1:0] Load_R,
    input  logic [WIDTH-1:0] Load_Q,
    input  logic [WIDTH-1:0] R_In,
    input  logic             Q_Bit,
    output logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;

    // Clr_En overrides the R half of a load so a start only needs Load_Q.
    always_comb begin
        r_d = r_q;
        q_d = q_q;
        if (Load_En) begin
            q_d = Load_Q;
            r_d = Clr_En ? '0 : Load_R;
        end else if (Clr_En) begin
            r_d = '0;
        end else if (Shift_En) begin
            r_d = R_In;
            q_d = {q_q[WIDTH-2:0], Q_Bit};
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_q <= '0;
            q_q <= '0;
        end else begin
            r_q <= r_d;
            q_q <= q_d;
        end
    end

    assign R = r_q;
    assign Q = q_q;

endmodule

// File: rtl/shift_sub_divider.sv
// rtl/shift_sub_divider.sv - iterative restoring divider; SHIFT_SUB_DIVIDER_SIGNED_EN adds signed operands
module shift_sub_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);

    localparam int CW = $clog2(WIDTH) + 1;

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    count_q, count_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] r_cur, q_cur;
    logic [WIDTH-1:0] r_shift, r_next;
    logic [WIDTH:0]   trial;
    logic             q_bit;
    logic             load_en, clr_en, shift_en;
    logic [WIDTH-1:0] load_r, load_q;
    logic [WIDTH-1:0] dividend_mag, divisor_mag;

`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
    logic sa_q, sa_d, sb_q, sb_d;
    assign dividend_mag = Dividend[WIDTH-1] ? -Dividend : Dividend;
    assign divisor_mag  = Divisor[WIDTH-1]  ? -Divisor  : Divisor;
`else
    assign dividend_mag = Dividend;
    assign divisor_mag  = Divisor;
`endif

    // A non-negative trial difference means the divisor fits: keep it and set the quotient bit.
    assign r_shift = {r_cur[WIDTH-2:0], q_cur[WIDTH-1]};
    assign trial   = {1'b0, r_shift} - {1'b0, d_q};
    assign q_bit   = ~trial[WIDTH];
    assign r_next  = q_bit ? trial[WIDTH-1:0] : r_shift;

    shift_left_reg #(.WIDTH(WIDTH)) u_rq (
        .Clk      (Clk),
        .Reset    (Reset),
        .Load_En  (load_en),
        .Clr_En   (clr_en),
        .Shift_En (shift_en),
        .Load_R   (load_r),
        .Load_Q   (load_q),
        .R_In     (r_next),
        .Q_Bit    (q_bit),
        .R        (r_cur),
        .Q        (q_cur)
    );

    always_comb begin
        state_d  = state_q;
        d_d      = d_q;
        count_d  = count_q;
        dbz_d    = dbz_q;
        load_en  = 1'b0;
        clr_en   = 1'b0;
        shift_en = 1'b0;
        load_r   = '0;
        load_q   = dividend_mag;
        Busy     = 1'b0;
        Done     = 1'b0;
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
        sa_d     = sa_q;
        sb_d     = sb_q;
`endif
        case (state_q)
            IDLE: begin
                if (Run) begin
                    load_en = 1'b1;
                    clr_en  = 1'b1;
                    d_d     = divisor_mag;
                    count_d = '0;
                    dbz_d   = (Divisor == '0);
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
                    sa_d    = Dividend[WIDTH-1];
                    sb_d    = Divisor[WIDTH-1];
`endif
                    state_d = CALC;
                end
            end
            CALC: begin
                Busy     = 1'b1;
                shift_en = 1'b1;
                count_d  = count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) begin
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
                    state_d = FIX;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
            FIX: begin
                Busy    = 1'b1;
                load_en = 1'b1;
                load_q  = (sa_q ^ sb_q) ? -q_cur : q_cur;
                load_r  = sa_q ? -r_cur : r_cur;
                state_d = DONE;
            end
`endif
            DONE: begin
                Done = 1'b1;
                if (!Run) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            d_q     <= '0;
            count_q <= '0;
            dbz_q   <= 1'b0;
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            count_q <= count_d;
            dbz_q   <= dbz_d;
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
            sa_q    <= sa_d;
            sb_q    <= sb_d;
`endif
        end
    end

    assign Quotient  = q_cur;
    assign Remainder = r_cur;
    assign DivByZero = dbz_q;

endmodule

// File: tb/tb_shift_sub_divider.sv
// tb/tb_shift_sub_divider.sv - randomized self-checking bench for shift_sub_divider
module tb_shift_sub_divider;

    localparam int W = 8;
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
    localparam int LAT = W + 2;
`else
    localparam int LAT = W + 1;
`endif

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Run;
    logic [W-1:0] Dividend, Divisor;
    logic [W-1:0] Quotient, Remainder;
    logic         Busy, Done, DivByZero;

    int checks = 0;
    int errors = 0;

    shift_sub_divider #(.WIDTH(W)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Run       (Run),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero)
    );

    always #5 Clk = ~Clk;

    // Arithmetic reference: truncating division, divide-by-zero gives all-ones magnitude.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        int qi, ri;
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
        int sa_i, sb_i;
        sa_i = int'($signed(a));
        sb_i = int'($signed(b));
        if (sb_i == 0) begin
            qi = (1 << W) - 1;
            ri = (sa_i < 0) ? -sa_i : sa_i;
            if (sa_i < 0) begin
                qi = -qi;
                ri = -ri;
            end
        end else begin
            qi = sa_i / sb_i;
            ri = sa_i % sb_i;
        end
`else
        if (b == '0) begin
            qi = (1 << W) - 1;
            ri = int'(a);
        end else begin
            qi = int'(a) / int'(b);
            ri = int'(a) % int'(b);
        end
`endif
        q = qi[W-1:0];
        r = ri[W-1:0];
    endfunction

    // One-cycle Run pulse; operands scrambled after the start edge; returns edges until Done.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat,
                          output logic [W-1:0] q, output logic [W-1:0] r, output logic dbz);
        Dividend = a;
        Divisor  = b;
        Run      = 1'b1;
        @(posedge Clk); #1;
        Run      = 1'b0;
        Dividend = W'($urandom);
        Divisor  = W'($urandom);
        lat = 1;
        while (!Done && lat < 50) begin
            @(posedge Clk); #1;
            lat++;
        end
        q   = Quotient;
        r   = Remainder;
        dbz = DivByZero;
        @(posedge Clk); #1;
    endtask

    task automatic test_reset;
        Reset = 1'b1; Run = 1'b0; Dividend = '0; Divisor = '0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        checks++;
        if ({Quotient, Remainder, Busy, Done, DivByZero} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got q=%h r=%h busy=%b done=%b dbz=%b, want all 0",
                     Quotient, Remainder, Busy, Done, DivByZero);
        end
    endtask

    task automatic test_directed;
        int lat;
        logic [W-1:0] q, r, eq, er;
        logic dbz;
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
        logic [W-1:0] av [3] = '{8'h9C, 8'h80, 8'h05};
        logic [W-1:0] bv [3] = '{8'h07, 8'hFF, 8'h00};
        logic [W-1:0] qv [3] = '{8'hF2, 8'h80, 8'hFF};
        logic [W-1:0] rv [3] = '{8'hFE, 8'h00, 8'h05};
        logic         zv [3] = '{1'b0, 1'b0, 1'b1};
        int n = 3;
`else
        logic [W-1:0] av [4] = '{8'd100, 8'd255, 8'd3, 8'd5};
        logic [W-1:0] bv [4] = '{8'd7, 8'd1, 8'd200, 8'd0};
        logic [W-1:0] qv [4] = '{8'd14, 8'd255, 8'd0, 8'hFF};
        logic [W-1:0] rv [4] = '{8'd2, 8'd0, 8'd3, 8'h05};
        logic         zv [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        int n = 4;
`endif
        for (int i = 0; i < n; i++) begin
            run_op(av[i], bv[i], lat, q, r, dbz);
            eq = qv[i];
            er = rv[i];
            checks++;
            if (lat != LAT) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d edges, want %0d", i, lat, LAT);
            end
            checks++;
            if (q !== eq || r !== er || dbz !== zv[i]) begin
                errors++;
                $display("FAIL directed_result[%0d] %h/%h: got q=%h r=%h dbz=%b, want q=%h r=%h dbz=%b",
                         i, av[i], bv[i], q, r, dbz, eq, er, zv[i]);
            end
            checks++;
            if (Done !== 1'b0 || Quotient !== eq || Remainder !== er) begin
                errors++;
                $display("FAIL idle_hold[%0d]: got done=%b q=%h r=%h, want done=0 q=%h r=%h",
                         i, Done, Quotient, Remainder, eq, er);
            end
        end
    endtask

    task automatic test_random;
        int lat;
        logic [W-1:0] a, b, q, r, eq, er;
        logic dbz;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom);
            b = (i % 8 == 0) ? '0 : W'($urandom_range(0, (i % 3 == 0) ? 15 : 255));
            ref_div(a, b, eq, er);
            run_op(a, b, lat, q, r, dbz);
            checks++;
            if (lat != LAT || q !== eq || r !== er || dbz !== (b == '0)) begin
                errors++;
                $display("FAIL random[%0d] %h/%h: got lat=%0d q=%h r=%h dbz=%b, want lat=%0d q=%h r=%h dbz=%b",
                         i, a, b, lat, q, r, dbz, LAT, eq, er, (b == '0));
            end
        end
    endtask

    task automatic test_run_held;
        int ops = 0;
        logic prev_done = 1'b0;
        logic [W-1:0] eq, er;
        Dividend = 8'd100; Divisor = 8'd7; Run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk); #1;
            if (Done && !prev_done) ops++;
            prev_done = Done;
        end
        checks++;
        if (ops != 1 || Done !== 1'b1) begin
            errors++;
            $display("FAIL run_held_single: got ops=%0d done=%b, want ops=1 done=1", ops, Done);
        end
        Run = 1'b0;
        @(posedge Clk); #1;
        checks++;
        if (Done !== 1'b0) begin
            errors++;
            $display("FAIL done_drop: got done=%b, want 0 one edge after Run falls", Done);
        end
        prev_done = 1'b0;
        Dividend = 8'd3; Divisor = 8'd200; Run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk); #1;
            if (Done && !prev_done) ops++;
            prev_done = Done;
        end
        ref_div(8'd3, 8'd200, eq, er);
        checks++;
        if (ops != 2 || Quotient !== eq || Remainder !== er) begin
            errors++;
            $display("FAIL run_held_second: got ops=%0d q=%h r=%h, want ops=2 q=%h r=%h",
                     ops, Quotient, Remainder, eq, er);
        end
        Run = 1'b0;
        @(posedge Clk); #1;
    endtask

    task automatic test_reset_mid;
        int lat;
        logic [W-1:0] q, r;
        logic dbz;
        Dividend = 8'd100; Divisor = 8'd0; Run = 1'b1;
        @(posedge Clk); #1;
        Run = 1'b0;
        checks++;
        if (Busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got busy=%b, want 1", Busy);
        end
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        checks++;
        if ({Quotient, Remainder, Busy, Done, DivByZero} !== '0) begin
            errors++;
            $display("FAIL reset_mid_op: got q=%h r=%h busy=%b done=%b dbz=%b, want all 0",
                     Quotient, Remainder, Busy, Done, DivByZero);
        end
        run_op(8'd100, 8'd7, lat, q, r, dbz);
        checks++;
        if (lat != LAT || q !== 8'd14 || r !== 8'd2 || dbz !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_op: got lat=%0d q=%h r=%h dbz=%b, want lat=%0d q=0e r=02 dbz=0",
                     lat, q, r, dbz, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_run_held();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
